// File: rtl/xosera_pkg.sv
// Shared video types and fade-control definitions for the output stage.
package xosera_pkg;

  // 12-bit colour word {R[11:8], G[7:4], B[3:0]}
  typedef logic [11:0] rgb_t;

  // Fade controller states
  typedef enum logic [1:0] {
    FADE_IDLE = 2'd0,
    FADE_WAIT = 2'd1,
    FADE_STEP = 2'd2
  } fade_state_t;

  // Full brightness: the scaler passes colours through unchanged at this level
  localparam logic [4:0] FADE_LEVEL_MAX = 5'd16;

  // Level a fade heads toward: 1 = fade in (full brightness), 0 = fade out (black)
  function automatic logic [4:0] fade_target(input logic dir);
    logic [4:0] tgt;
    if (dir) begin
      tgt = FADE_LEVEL_MAX;
    end else begin
      tgt = 5'd0;
    end
    return tgt;
  endfunction

endpackage

// File: rtl/video_fade_scale.sv
// One colour channel scaled by the fade level: (chan * level) >> 4, truncated.
// Level 16 reproduces the channel exactly, level 0 yields black.
module video_fade_scale (
  input  logic [3:0] chan,
  input  logic [4:0] level,
  output logic [3:0] result
);

  logic [8:0] product_s;

  // 4x5 product; the largest legal product (15*16) fits in 8 bits
  assign product_s = {5'd0, chan} * {4'd0, level};

  // Keep the integer part; bit 8 only sets for out-of-range levels, so clamp to full scale then
  always_comb begin
    if (product_s[8]) begin
      result = 4'hF;
    end else begin
      result = product_s[7:4];
    end
  end

endmodule

// File: rtl/video_fade_out.sv
// Final video stage: scales blended RGB by a global brightness level that only
// moves on frame boundaries, and delays syncs/enable to stay aligned with it.
module video_fade_out
  import xosera_pkg::*;
#(
  parameter logic       VSYNC_POLARITY = 1'b0,
  parameter logic [4:0] RESET_LEVEL    = 5'd16
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        vsync_i,
  input  logic        hsync_i,
  input  logic        dv_de_i,
  input  logic [11:0] rgb_i,
  input  logic        fade_start_i,
  input  logic        fade_dir_i,
  input  logic [3:0]  fade_rate_i,
  output logic [11:0] rgb_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        dv_de_o,
  output logic        fade_busy_o,
  output logic        fade_done_o,
  output logic [4:0]  fade_level_o
);

  // ---------------------------------------------------------------------
  // Pipeline stage 1: raw pixel, syncs and the level in force for it
  // ---------------------------------------------------------------------
  rgb_t        rgb_s1_r;
  logic        hs_s1_r;
  logic        vs_s1_r;
  logic        de_s1_r;
  logic [4:0]  lvl_s1_r;

  // Frame-tick edge history of vsync_i ([0] newest)
  logic [1:0]  vs_hist_r;
  logic        tick_s;

  // Fade controller state
  fade_state_t state_r;
  fade_state_t state_n_s;
  logic [4:0]  level_r;
  logic [4:0]  level_n_s;
  logic [4:0]  level_step_s;
  logic [3:0]  frame_cnt_r;
  logic [3:0]  frame_cnt_n_s;
  logic        dir_r;
  logic        dir_n_s;
  logic [3:0]  rate_r;
  logic [3:0]  rate_n_s;
  logic        busy_r;
  logic        busy_n_s;
  logic        done_r;
  logic        done_n_s;

  // Stage-2 colour
  rgb_t        scaled_s;
  rgb_t        rgb_n_s;

  // Capture the incoming pixel and the current level together, so a level
  // change lands atomically on a pixel boundary
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rgb_s1_r <= 12'h000;
      hs_s1_r  <= 1'b0;
      vs_s1_r  <= 1'b0;
      de_s1_r  <= 1'b0;
      lvl_s1_r <= RESET_LEVEL;
    end else begin
      rgb_s1_r <= rgb_i;
      hs_s1_r  <= hsync_i;
      vs_s1_r  <= vsync_i;
      de_s1_r  <= dv_de_i;
      lvl_s1_r <= level_r;
    end
  end

  // Per-channel scalers
  video_fade_scale u_scale_r (
    .chan   (rgb_s1_r[11:8]),
    .level  (lvl_s1_r),
    .result (scaled_s[11:8])
  );

  video_fade_scale u_scale_g (
    .chan   (rgb_s1_r[7:4]),
    .level  (lvl_s1_r),
    .result (scaled_s[7:4])
  );

  video_fade_scale u_scale_b (
    .chan   (rgb_s1_r[3:0]),
    .level  (lvl_s1_r),
    .result (scaled_s[3:0])
  );

  // Blank the colour outside the display-enable window
  always_comb begin
    if (de_s1_r) begin
      rgb_n_s = scaled_s;
    end else begin
      rgb_n_s = 12'h000;
    end
  end

  // Pipeline stage 2: registered outputs, two cycles behind the inputs
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rgb_o   <= 12'h000;
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
      dv_de_o <= 1'b0;
    end else begin
      rgb_o   <= rgb_n_s;
      hsync_o <= hs_s1_r;
      vsync_o <= vs_s1_r;
      dv_de_o <= de_s1_r;
    end
  end

  // ---------------------------------------------------------------------
  // Frame tick: registered vsync moving from inactive to active level
  // ---------------------------------------------------------------------

  // Edge history starts at the inactive level so reset never fakes a tick
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vs_hist_r <= {2{~VSYNC_POLARITY}};
    end else begin
      vs_hist_r <= {vs_hist_r[0], vsync_i};
    end
  end

  assign tick_s = (vs_hist_r[0] == VSYNC_POLARITY) && (vs_hist_r[1] != VSYNC_POLARITY);

  // ---------------------------------------------------------------------
  // Fade controller
  // ---------------------------------------------------------------------

  // One level step toward the latched direction, saturating at both ends
  always_comb begin
    if (dir_r) begin
      if (level_r >= FADE_LEVEL_MAX) begin
        level_step_s = FADE_LEVEL_MAX;
      end else begin
        level_step_s = level_r + 5'd1;
      end
    end else begin
      if (level_r == 5'd0) begin
        level_step_s = 5'd0;
      end else begin
        level_step_s = level_r - 5'd1;
      end
    end
  end

  // Next-state logic; a start request overrides everything, including a
  // coincident frame tick, and restarts from the current level
  always_comb begin
    state_n_s     = state_r;
    level_n_s     = level_r;
    frame_cnt_n_s = frame_cnt_r;
    dir_n_s       = dir_r;
    rate_n_s      = rate_r;
    done_n_s      = 1'b0;

    if (fade_start_i) begin
      dir_n_s       = fade_dir_i;
      rate_n_s      = fade_rate_i;
      frame_cnt_n_s = fade_rate_i;
      if (level_r == fade_target(fade_dir_i)) begin
        state_n_s = FADE_IDLE;
        done_n_s  = 1'b1;
      end else begin
        state_n_s = FADE_WAIT;
      end
    end else begin
      case (state_r)
        FADE_IDLE: begin
          state_n_s = FADE_IDLE;
        end
        FADE_WAIT: begin
          if (tick_s) begin
            if (frame_cnt_r == 4'd0) begin
              state_n_s = FADE_STEP;
            end else begin
              frame_cnt_n_s = frame_cnt_r - 4'd1;
            end
          end else begin
            state_n_s = FADE_WAIT;
          end
        end
        FADE_STEP: begin
          level_n_s = level_step_s;
          if (level_step_s == fade_target(dir_r)) begin
            state_n_s = FADE_IDLE;
            done_n_s  = 1'b1;
          end else begin
            frame_cnt_n_s = rate_r;
            state_n_s     = FADE_WAIT;
          end
        end
        default: begin
          state_n_s = FADE_IDLE;
        end
      endcase
    end

    busy_n_s = (state_n_s != FADE_IDLE);
  end

  // Controller registers; busy and done are registered alongside the state
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= FADE_IDLE;
      level_r     <= RESET_LEVEL;
      frame_cnt_r <= 4'd0;
      dir_r       <= 1'b0;
      rate_r      <= 4'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      level_r     <= level_n_s;
      frame_cnt_r <= frame_cnt_n_s;
      dir_r       <= dir_n_s;
      rate_r      <= rate_n_s;
      busy_r      <= busy_n_s;
      done_r      <= done_n_s;
    end
  end

  assign fade_busy_o  = busy_r;
  assign fade_done_o  = done_r;
  assign fade_level_o = level_r;

endmodule
